// File: rtl/mii_tx_fifo.sv
// mii_tx_fifo: MII transmit elastic buffer between the MII input stage and the PCS transmitter.
// Ports:
//   clk, rst                       rising-edge clock, asynchronous active-high reset
//   in_ce, in_enable, in_err, in_data   input strobe with TX_EN / TX_ER / TXD nibble
//   out_ready                      consumer request for one nibble
//   out_enable, out_err, out_data  registered presented nibble
//   level                          current occupancy
//   underflow, overflow            one-cycle error pulses
module mii_tx_fifo #(
   parameter int DEPTH     = 8,
   parameter int THRESHOLD = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_ce,
   input  logic                     in_enable,
   input  logic                     in_err,
   input  logic [3:0]               in_data,
   input  logic                     out_ready,
   output logic                     out_enable,
   output logic                     out_err,
   output logic [3:0]               out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     underflow,
   output logic                     overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0] THR = (AW+1)'(THRESHOLD);
   localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, DISCARD = 2'd3;

   logic [1:0]    state, state_nxt;
   logic [5:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   level_nxt;
   logic [5:0]    head;
   logic          corrupt, pop_req, pop, udf, wr_try, wr, ovf, full;

   always_comb begin
      head      = mem[rd_ptr];
      full      = level == FULL_LVL;
      pop_req   = out_ready && state == RUN;
      pop       = pop_req && level != '0;
      udf       = pop_req && level == '0;
      // a write colliding with an underflow read is lost along with the frame
      wr_try    = in_ce && state != DISCARD && (in_enable || state == FILL || state == RUN) && !udf;
      // a same-edge pop frees a slot before the write lands
      wr        = wr_try && (!full || pop);
      ovf       = wr_try && full && !pop;
      level_nxt = level + {AW'(0), wr} - {AW'(0), pop};
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = (wr && in_enable) ? FILL : IDLE;
         FILL:    state_nxt = (level_nxt >= THR || (wr && !in_enable)) ? RUN : FILL;
         RUN:     state_nxt = udf ? DISCARD : (pop && !head[5]) ? IDLE : RUN;
         default: state_nxt = (in_ce && !in_enable) ? IDLE : DISCARD;
      endcase
   end

   always_ff @(posedge clk)
      if (wr) mem[wr_ptr] <= {in_enable, in_err, in_data};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         corrupt    <= 1'b0;
         out_enable <= 1'b0;
         out_err    <= 1'b0;
         out_data   <= 4'h0;
         underflow  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state     <= state_nxt;
         underflow <= udf;
         overflow  <= ovf;
         if (state == DISCARD) begin
            rd_ptr <= wr_ptr;
            level  <= '0;
         end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
         end
         // an end-of-frame entry leaving the FIFO closes the damaged frame
         corrupt <= ovf ? 1'b1 : (pop && !head[5]) ? 1'b0 : corrupt;
         if (out_ready)
            {out_enable, out_err, out_data} <= pop ? {head[5], head[4] | (corrupt & head[5]), head[3:0]} :
                                               udf ? 6'b110000 : 6'b000000;
      end
   end
endmodule

// File: tb/tb_mii_tx_fifo.sv
// tb_mii_tx_fifo: directed self-checking bench for mii_tx_fifo (DEPTH=8, THRESHOLD=4).
module tb_mii_tx_fifo;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_ce = 1'b0, in_enable = 1'b0, in_err = 1'b0, out_ready = 1'b0;
   logic [3:0] in_data = 4'h0;
   logic       out_enable, out_err, underflow, overflow;
   logic [3:0] out_data;
   logic [3:0] level;
   int checks = 0;
   int errors = 0;

   mii_tx_fifo #(.DEPTH(8), .THRESHOLD(4)) dut (
      .clk(clk), .rst(rst), .in_ce(in_ce), .in_enable(in_enable), .in_err(in_err),
      .in_data(in_data), .out_ready(out_ready), .out_enable(out_enable), .out_err(out_err),
      .out_data(out_data), .level(level), .underflow(underflow), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic en, input logic er, input logic [3:0] d);
      check(tag, {2'b00, out_enable, out_err, out_data}, {2'b00, en, er, d});
   endtask

   task automatic step(input logic ce, input logic en, input logic er, input logic [3:0] d, input logic rdy);
      in_ce = ce;
      in_enable = en;
      in_err = er;
      in_data = d;
      out_ready = rdy;
      @(posedge clk);
      #1;
      in_ce = 1'b0;
      out_ready = 1'b0;
   endtask

   function automatic logic [3:0] nib(input int i);
      return i < 15 ? 4'h5 : i == 15 ? 4'hD : i < 20 ? 4'(i - 15) : 4'h0;
   endfunction

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_out("reset_out", 0, 0, 4'h0);
      check("reset_level", 8'(level), 8'd0);
      check("reset_flags", {6'b0, underflow, overflow}, 8'd0);
      rst = 1'b0;
      step(0, 0, 0, 0, 0);

      // 21-entry frame (20 nibbles + end marker), writes every 5 clocks, reads every 5 offset 2
      for (int c = 0; c < 130; c++) begin
         step(c % 5 == 0 && c / 5 <= 20, c / 5 < 20, 1'b0, nib(c / 5), c % 5 == 2);
         if (c % 5 == 2) begin
            if (c / 5 >= 3 && c / 5 <= 23) chk_out("frame_nibble", c / 5 - 3 < 20, 1'b0, nib(c / 5 - 3));
            else chk_out("frame_idle", 0, 0, 4'h0);
            check("frame_underflow", {7'b0, underflow}, 8'd0);
         end
      end
      check("frame_level_end", 8'(level), 8'd0);

      // short frame: end marker before threshold releases it
      step(1, 1, 0, 4'h5, 0);
      step(1, 1, 0, 4'h5, 0);
      step(1, 0, 0, 4'h0, 0);
      check("short_level", 8'(level), 8'd3);
      step(0, 0, 0, 0, 1);
      chk_out("short_n0", 1, 0, 4'h5);
      step(0, 0, 0, 0, 1);
      chk_out("short_n1", 1, 0, 4'h5);
      step(0, 0, 0, 0, 1);
      chk_out("short_end", 0, 0, 4'h0);
      check("short_underflow", {7'b0, underflow}, 8'd0);
      step(0, 0, 0, 0, 1);
      chk_out("short_idle", 0, 0, 4'h0);
      check("short_idle_underflow", {7'b0, underflow}, 8'd0);

      // underflow with a colliding write, then DISCARD until in_enable falls
      for (int i = 1; i <= 4; i++) step(1, 1, 0, 4'(i), 0);
      for (int i = 1; i <= 4; i++) begin
         step(0, 0, 0, 0, 1);
         chk_out("udf_pre", 1, 0, 4'(i));
      end
      step(1, 1, 0, 4'h5, 1);
      chk_out("udf_out", 1, 1, 4'h0);
      check("udf_pulse", {6'b0, underflow, overflow}, 8'd2);
      check("udf_level", 8'(level), 8'd0);
      step(0, 0, 0, 0, 0);
      check("udf_pulse_end", {7'b0, underflow}, 8'd0);
      step(1, 1, 0, 4'h7, 0);
      check("discard_drop", 8'(level), 8'd0);
      step(1, 0, 0, 4'h0, 0);
      check("discard_exit", 8'(level), 8'd0);

      // overflow: 10 writes, no reads
      for (int i = 0; i < 10; i++) begin
         step(1, 1, 0, 4'(i), 0);
         check("ovf_pulse", {7'b0, overflow}, {7'b0, i >= 8});
      end
      check("ovf_level", 8'(level), 8'd8);
      step(0, 0, 0, 0, 0);
      check("ovf_pulse_end", {7'b0, overflow}, 8'd0);
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 0, 0, 1);
         chk_out("ovf_drain", 1, 1, 4'(i));
      end
      check("ovf_drained", 8'(level), 8'd0);
      step(1, 0, 0, 4'h0, 0);
      check("ovf_marker_level", 8'(level), 8'd1);
      step(0, 0, 0, 0, 1);
      chk_out("ovf_marker", 0, 0, 4'h0);

      // full FIFO with same-edge pop and write
      for (int i = 0; i < 8; i++) step(1, 1, 0, 4'(8 + i), 0);
      check("full_level", 8'(level), 8'd8);
      step(1, 1, 0, 4'h3, 1);
      chk_out("full_pop", 1, 0, 4'h8);
      check("full_level_kept", 8'(level), 8'd8);
      check("full_no_ovf", {7'b0, overflow}, 8'd0);
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 0, 0, 1);
         chk_out("full_drain", 1, 0, i < 7 ? 4'(9 + i) : 4'h3);
      end
      step(1, 0, 0, 4'h0, 0);
      step(0, 0, 0, 0, 1);
      chk_out("full_marker", 0, 0, 4'h0);

      // asynchronous reset mid-frame
      for (int i = 1; i <= 5; i++) step(1, 1, 0, 4'(i), 0);
      step(0, 0, 0, 0, 1);
      chk_out("rst_pre_out", 1, 0, 4'h1);
      check("rst_pre_level", 8'(level), 8'd4);
      #1 rst = 1'b1;
      #2;
      chk_out("rst_async_out", 0, 0, 4'h0);
      check("rst_async_level", 8'(level), 8'd0);
      check("rst_async_flags", {6'b0, underflow, overflow}, 8'd0);
      rst = 1'b0;
      #2;
      for (int i = 6; i <= 9; i++) step(1, 1, 0, 4'(i), 0);
      step(1, 0, 0, 4'h0, 0);
      check("post_rst_level", 8'(level), 8'd5);
      for (int i = 6; i <= 9; i++) begin
         step(0, 0, 0, 0, 1);
         chk_out("post_rst_nibble", 1, 0, 4'(i));
      end
      step(0, 0, 0, 0, 1);
      chk_out("post_rst_end", 0, 0, 4'h0);
      check("post_rst_final_level", 8'(level), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
